// File: rtl/divisor.sv
// rtl/divisor.sv - sequential restoring divider, one quotient bit per clock
// Control unit (unidade_controle) sequences a datapath (fluxo_dados) with an iteration counter (REGN).
module divisor #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] Q,
  output logic [n-1:0] R,
  output logic         dz,
  output logic         finish
);

  logic ld_norm;
  logic ld_dz;
  logic step;
  logic b_zero;
  logic last_iter;

  divisor_ctrl unidade_controle (
    .clk         (clk),
    .reset       (reset),
    .init_i      (init),
    .b_zero_i    (b_zero),
    .last_iter_i (last_iter),
    .ld_norm_o   (ld_norm),
    .ld_dz_o     (ld_dz),
    .step_o      (step),
    .finish_o    (finish)
  );

  divisor_dp #(.n(n)) fluxo_dados (
    .clk         (clk),
    .reset       (reset),
    .a_i         (A),
    .b_i         (B),
    .ld_norm_i   (ld_norm),
    .ld_dz_i     (ld_dz),
    .step_i      (step),
    .b_zero_o    (b_zero),
    .last_iter_o (last_iter),
    .q_o         (Q),
    .r_o         (R),
    .dz_o        (dz)
  );

endmodule

module divisor_ctrl (
  input  logic clk,
  input  logic reset,
  input  logic init_i,
  input  logic b_zero_i,
  input  logic last_iter_i,
  output logic ld_norm_o,
  output logic ld_dz_o,
  output logic step_o,
  output logic finish_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    ld_norm_o = 1'b0;
    ld_dz_o   = 1'b0;
    step_o    = 1'b0;
    case (state)
      // DONE accepts a new start exactly like IDLE, so back-to-back operations need no idle cycle
      IDLE, DONE: begin
        if (init_i) begin
          if (b_zero_i) begin
            ld_dz_o = 1'b1;
            state_d = DONE;
          end else begin
            ld_norm_o = 1'b1;
            state_d   = ITER;
          end
        end
      end
      ITER: begin
        step_o = 1'b1;
        if (last_iter_i) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign finish_o = (state == DONE);

endmodule

module divisor_dp #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  input  logic         ld_norm_i,
  input  logic         ld_dz_i,
  input  logic         step_i,
  output logic         b_zero_o,
  output logic         last_iter_o,
  output logic [n-1:0] q_o,
  output logic [n-1:0] r_o,
  output logic         dz_o
);

  localparam int CW = $clog2(n + 1);

  logic [n:0]   rr_q, rr_d;
  logic [n-1:0] rq_q, rq_d;
  logic [n-1:0] rb_q, rb_d;
  logic         dz_q, dz_d;
  logic [CW-1:0] regn_q;

  logic [2*n:0] s;
  logic [n:0]   s_hi;
  logic [n:0]   t;

  assign s    = {rr_q, rq_q} << 1;
  assign s_hi = s[2*n:n];
  assign t    = s_hi - {1'b0, rb_q};

  divisor_cnt #(.W(CW)) REGN (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ld_norm_i),
    .load_val_i (CW'(n)),
    .dec_i      (step_i),
    .q          (regn_q)
  );

  always_comb begin
    rr_d = rr_q;
    rq_d = rq_q;
    rb_d = rb_q;
    dz_d = dz_q;
    if (ld_norm_i) begin
      rr_d = '0;
      rq_d = a_i;
      rb_d = b_i;
      dz_d = 1'b0;
    end else if (ld_dz_i) begin
      rr_d = {1'b0, a_i};
      rq_d = '1;
      dz_d = 1'b1;
    end else if (step_i) begin
      // Restore (keep the shifted value) whenever the trial subtraction went negative
      rr_d = t[n] ? s_hi : t;
      rq_d = s[n-1:0] | {{(n-1){1'b0}}, ~t[n]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= '0;
      rq_q <= '0;
      rb_q <= '0;
      dz_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      rq_q <= rq_d;
      rb_q <= rb_d;
      dz_q <= dz_d;
    end
  end

  assign b_zero_o    = (b_i == '0);
  assign last_iter_o = (regn_q == CW'(1));
  assign q_o         = rq_q;
  assign r_o         = rr_q[n-1:0];
  assign dz_o        = dz_q;

endmodule

module divisor_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load_i) begin
      q <= load_val_i;
    end else if (dec_i) begin
      q <= q - W'(1);
    end
  end

endmodule

// File: tb/tb_divisor.sv
// tb/tb_divisor.sv - self-checking bench for divisor against an arithmetic reference model
module tb_divisor;

  localparam int N    = 8;
  localparam int ONES = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         dz;
  logic         finish;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  divisor #(.n(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .init   (init),
    .A      (A),
    .B      (B),
    .Q      (Q),
    .R      (R),
    .dz     (dz),
    .finish (finish)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic expect_result(input string tag, input int a, input int b);
    int eq, er, edz;
    if (b == 0) begin
      eq = ONES; er = a; edz = 1;
    end else begin
      eq = a / b; er = a % b; edz = 0;
    end
    check({tag, "_finish"}, finish, 1);
    check({tag, "_q"}, Q, eq);
    check({tag, "_r"}, R, er);
    check({tag, "_dz"}, dz, edz);
  endtask

  task automatic run_op(input string tag, input int a, input int b);
    int lat;
    @(negedge clk);
    A = N'(a); B = N'(b); init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    lat  = 1;
    if (b != 0) begin
      check({tag, "_finish_drop"}, finish, 0);
      check({tag, "_regn_load"}, dut.fluxo_dados.REGN.q, N);
    end
    while (!finish && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, (b == 0) ? 1 : N + 1);
    if (b != 0) check({tag, "_regn_end"}, dut.fluxo_dados.REGN.q, 0);
  endtask

  initial begin
    int lat;
    int seen;
    int a, b;
    int pairs[8][2] = '{'{42, 6}, '{255, 16}, '{255, 1}, '{255, 255},
                        '{7, 9}, '{0, 5}, '{200, 0}, '{100, 3}};

    reset = 1'b1; init = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(dut.unidade_controle.state), 0);
    check("rst_finish", finish, 0);
    check("rst_q", Q, 0);
    check("rst_r", R, 0);
    check("rst_dz", dz, 0);
    check("rst_regn", dut.fluxo_dados.REGN.q, 0);

    foreach (pairs[i]) begin
      run_op($sformatf("dir%0d", i), pairs[i][0], pairs[i][1]);
      expect_result($sformatf("dir%0d", i), pairs[i][0], pairs[i][1]);
    end

    // Inputs changing after completion must not disturb the held result
    A = N'($urandom); B = N'($urandom);
    repeat (3) @(negedge clk);
    expect_result("hold", 100, 3);

    // Stray init during ITER, sampled on the 4th edge of the operation
    @(negedge clk);
    A = 8'd42; B = 8'd6; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    lat  = 1;
    while (!finish && lat < 40) begin
      if (lat == 3) begin
        init = 1'b1; A = 8'd99; B = 8'd0;
      end else begin
        init = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    init = 1'b0;
    check("stray_latency", lat, N + 1);
    expect_result("stray", 42, 6);

    // Reset sampled on the 5th edge aborts the operation
    @(negedge clk);
    A = 8'd100; B = 8'd7; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    lat  = 1;
    while (lat < 4) begin
      @(negedge clk);
      lat++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", 32'(dut.unidade_controle.state), 0);
    check("abort_finish", finish, 0);
    check("abort_q", Q, 0);
    check("abort_r", R, 0);
    check("abort_dz", dz, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (finish) seen = 1;
    end
    check("abort_no_finish", seen, 0);

    for (int i = 0; i < 200; i++) begin
      a = int'($urandom_range(0, ONES));
      b = int'($urandom_range(1, ONES));
      run_op($sformatf("rnd%0d", i), a, b);
      expect_result($sformatf("rnd%0d", i), a, b);
      check($sformatf("rnd%0d_inv", i), int'(Q) * b + int'(R), a);
      check($sformatf("rnd%0d_rltb", i), int'(R) < b, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
